// File: rtl/ucore_useq_if.sv
// Sequencer <-> core bundle: control-store sequencing fields in, uPC/stack status out.
// Combinational control store sits on the master side: upc out, seq_op/seq_tgt back the same cycle.
interface ucore_useq_if #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    logic                             restart;
    logic                             stall;
    logic [2:0]                       seq_op;
    logic [AW-1:0]                    seq_tgt;
    logic                             cond;
    logic [AW-1:0]                    dispatch_addr;
    logic                             wait_done;
    logic [AW-1:0]                    upc;
    logic [$clog2(DEPTH+1)-1:0]       stack_depth;
    logic                             fault;

    modport master (
        output restart, stall, seq_op, seq_tgt, cond, dispatch_addr, wait_done,
        input  upc, stack_depth, fault
    );

    modport slave (
        input  restart, stall, seq_op, seq_tgt, cond, dispatch_addr, wait_done,
        output upc, stack_depth, fault
    );
endinterface

// File: rtl/ucore_useq.sv
// Microcode sequencer: uPC plus return stack; next address is registered (1-cycle latency).
// stall freezes all state; restart overrides stall and clears a stack fault.
module ucore_useq #(
    parameter int            AW         = 8,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic         clk,
    input  logic         aresetn,
    ucore_useq_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRT      = 3'd2;
    localparam logic [2:0] OP_BRF      = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;
    localparam logic [2:0] OP_DISPATCH = 3'd6;
    localparam logic [2:0] OP_WAIT     = 3'd7;

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t         r_state;
    logic [AW-1:0]  r_upc;
    logic [DW-1:0]  r_depth;
    logic [AW-1:0]  r_stack [DEPTH];

    logic [AW-1:0]  w_inc;
    logic           w_can_push;
    logic           w_can_pop;
    logic           w_push;
    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_top_idx;

    assign w_inc      = r_upc + 1'b1;
    assign w_can_push = (r_depth != DEPTH_W);
    assign w_can_pop  = (r_depth != '0);
    assign w_push_idx = IW'(r_depth);
    assign w_top_idx  = IW'(r_depth - 1'b1);
    assign w_push     = !bus.restart && !bus.stall && (r_state == S_RUN) &&
                        (bus.seq_op == OP_CALL) && w_can_push;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_RUN;
            r_upc   <= RESET_ADDR;
            r_depth <= '0;
        end else if (bus.restart) begin
            r_state <= S_RUN;
            r_upc   <= RESET_ADDR;
            r_depth <= '0;
        end else if (!bus.stall) begin
            case (r_state)
                S_RUN: begin
                    case (bus.seq_op)
                        OP_NEXT:     r_upc <= w_inc;
                        OP_JUMP:     r_upc <= bus.seq_tgt;
                        OP_BRT:      r_upc <= bus.cond ? bus.seq_tgt : w_inc;
                        OP_BRF:      r_upc <= bus.cond ? w_inc : bus.seq_tgt;
                        OP_CALL: begin
                            if (w_can_push) begin
                                r_upc   <= bus.seq_tgt;
                                r_depth <= r_depth + 1'b1;
                            end else begin
                                r_state <= S_FAULT;
                            end
                        end
                        OP_RET: begin
                            if (w_can_pop) begin
                                r_upc   <= r_stack[w_top_idx];
                                r_depth <= r_depth - 1'b1;
                            end else begin
                                r_state <= S_FAULT;
                            end
                        end
                        OP_DISPATCH: r_upc <= bus.dispatch_addr;
                        OP_WAIT:     r_upc <= bus.wait_done ? w_inc : r_upc;
                    endcase
                end
                S_FAULT: ;
            endcase
        end
    end

    // Stack storage needs no reset: entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (w_push) r_stack[w_push_idx] <= w_inc;
    end

    assign bus.upc         = r_upc;
    assign bus.stack_depth = r_depth;
    assign bus.fault       = (r_state == S_FAULT);
endmodule
